// File: rtl/pim_shift_pkg.sv
// Shared definitions for the PIM sequential shifters.
// State encodings and counter-width helper.
package pim_shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int cnt_width(input int sw);
    return $clog2(sw + 1);
  endfunction

endpackage

// File: rtl/shift_l_stage.sv
// One barrel stage: shift or rotate left by 1<<idx when en.
// Rotate variant selected by SHIFT_L_ROTATE_EN.
module shift_l_stage
  import pim_shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5,
  localparam int CW         = cnt_width(SHIFT_WIDTH)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [CW-1:0]    idx,
  input  logic             en,
  output logic [WIDTH-1:0] nxt
);

  int sh;
`ifdef SHIFT_L_ROTATE_EN
  int rot;
`endif

  always_comb begin
    sh  = 1 << idx;
    nxt = acc;
`ifdef SHIFT_L_ROTATE_EN
    rot = sh % WIDTH;
    if (en)
      nxt = (acc << rot) | (acc >> (WIDTH - rot));
`else
    if (en)
      nxt = acc << sh;
`endif
  end

endmodule

// File: rtl/shift_l_seq_nbit.sv
// Multi-cycle left shifter, one barrel stage per clock.
// SHIFT_L_ROTATE_EN turns each stage into a rotate.
module shift_l_seq_nbit
  import pim_shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       A,
  input  logic [SHIFT_WIDTH-1:0] B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       Y
);

  localparam int CW = cnt_width(SHIFT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SHIFT_WIDTH - 1);

  logic [1:0]             state;
  logic [WIDTH-1:0]       acc;
  logic [WIDTH-1:0]       nxt;
  logic [SHIFT_WIDTH-1:0] amt;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       y_q;

  shift_l_stage #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_stage (
    .acc (acc),
    .idx (cnt),
    .en  (amt[cnt]),
    .nxt (nxt)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign Y         = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      amt   <= '0;
      cnt   <= '0;
      y_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc   <= A;
            amt   <= B;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc <= nxt;
          // Y captures the final stage so it equals acc throughout DONE
          if (cnt == LAST) begin
            state <= ST_DONE;
            y_q   <= nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_l_seq_nbit.sv
// Directed and randomized bench for shift_l_seq_nbit.
// Expected values follow SHIFT_L_ROTATE_EN when defined.
module tb_shift_l_seq_nbit;

  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [4:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Y;

  int checks   = 0;
  int failures = 0;

  shift_l_seq_nbit #(.WIDTH(32), .SHIFT_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [4:0] b);
`ifdef SHIFT_L_ROTATE_EN
    return (a << b) | (a >> (32 - int'(b)));
`else
    return a << b;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one op from IDLE, return result and accept-to-valid latency.
  task automatic run_op(input logic [31:0] a, input logic [4:0] b,
                        output logic [31:0] y, output int lat);
    A = a;
    B = b;
    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    y = Y;
    step();
  endtask

  logic [31:0] y, y0, exp_q[$], e;
  int lat, nvalid, sent, got;
  logic acc_fire, out_fire;

  initial begin
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    A = 0;
    B = 0;
    repeat (2) step();
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", Y, 32'd0);

    // basic shift and latency
    A = 32'h0000_00FF;
    B = 5'd4;
    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    chk("basic_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("basic_lat", 32'(lat), 32'd5);
    chk("basic_y", Y, 32'h0000_0FF0);
    chk("basic_rdy_low", 32'(in_ready), 32'd0);
    step();
    chk("basic_rdy_back", 32'(in_ready), 32'd1);
    chk("basic_ov_drop", 32'(out_valid), 32'd0);

    // reset in the middle of SHIFT
    A = 32'h1;
    B = 5'd7;
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    rst = 1;
    repeat (3) step();
    rst = 0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", Y, 32'd0);
    nvalid = 0;
    repeat (10) begin
      step();
      if (out_valid) nvalid++;
    end
    chk("midrst_stray", 32'(nvalid), 32'd0);

    // boundary amounts
    run_op(32'hDEAD_BEEF, 5'd0, y, lat);
    chk("b0_y", y, 32'hDEAD_BEEF);
    chk("b0_lat", 32'(lat), 32'd5);
    run_op(32'h0000_0003, 5'd31, y, lat);
`ifdef SHIFT_L_ROTATE_EN
    chk("b31_y", y, 32'h8000_0001);
`else
    chk("b31_y", y, 32'h8000_0000);
`endif
    run_op(32'h8000_0001, 5'd1, y, lat);
`ifdef SHIFT_L_ROTATE_EN
    chk("rot1_y", y, 32'h0000_0003);
`else
    chk("rot1_y", y, 32'h0000_0002);
`endif
    run_op(32'h1234_5678, 5'd16, y, lat);
`ifdef SHIFT_L_ROTATE_EN
    chk("rot16_y", y, 32'h5678_1234);
`else
    chk("rot16_y", y, 32'h5678_0000);
`endif

    // backpressure: hold DONE while offering another op
    A = 32'h0000_0001;
    B = 5'd3;
    in_valid = 1;
    out_ready = 0;
    step();
    A = 32'hFFFF_FFFF;
    B = 5'd1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd5);
    chk("bp_y", Y, 32'h0000_0008);
    y0 = Y;
    repeat (10) begin
      step();
      chk("bp_hold_y", Y, y0);
      chk("bp_hold_ov", 32'(out_valid), 32'd1);
      chk("bp_no_accept", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    step();
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    step();
    in_valid = 0;
    chk("bp_next_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("bp_next_lat", 32'(lat), 32'd5);
    chk("bp_next_y", Y, model(32'hFFFF_FFFF, 5'd1));
    step();

    // randomized stream with gaps on both sides
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
      in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      A = $urandom;
      B = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 2) != 0);
      acc_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("rand_y", Y, e);
        got++;
      end
      if (acc_fire) begin
        exp_q.push_back(model(A, B));
        sent++;
      end
      step();
    end
    in_valid = 0;
    chk("rand_sent", 32'(sent), 32'd100);
    chk("rand_got", 32'(got), 32'd100);
    chk("rand_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
